// File: rtl/huff_code_rx_pkg.sv
// Shared definitions for the Huffman code-table link (transmitter and receiver).
package huff_code_rx_pkg;

  localparam int HUFF_NUM_SYM = 10;  // code-table entries per frame
  localparam int HUFF_LEN_W   = 4;   // serial length field width
  localparam int HUFF_MAX_LEN = 9;   // largest legal code length
  localparam int HUFF_CODE_W  = 13;  // stored word: [12:9] length, [8:0] code

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LEN  = 2'b01,
    ST_CODE = 2'b10,
    ST_DONE = 2'b11
  } huff_state_e;

endpackage

// File: rtl/huff_code_rx_shift_acc.sv
// Bit counter plus MSB-first shift accumulator, reused for the length and
// code fields. Only ACC_W-1 bits are registered: the final bit of a field is
// taken straight from bit_i through acc_nxt_o on the edge that samples it.
module huff_shift_acc #(
  parameter int ACC_W = 9,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_cnt_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [ACC_W-1:0] acc_nxt_o,
  output logic             last_o
);

  logic [ACC_W-2:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign acc_nxt_o = {acc_q, bit_i};
  assign last_o    = (cnt_q == CNT_W'(1));

  // Clear beats load beats shift; load zeroes the accumulator and arms the count.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load_i) begin
      acc_d = '0;
      cnt_d = load_cnt_i;
    end else if (shift_i) begin
      acc_d = acc_nxt_o[ACC_W-2:0];
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/huff_code_rx.sv
// Serial Huffman code-table receiver: per symbol a length field then that many
// code bits, both MSB-first, stored as {length, right-aligned code}.
// Handshake: a bit on In is consumed only on a rising edge with In_vld=1 while
// the block is receiving; Start_in on the same edge takes priority and the bit
// is dropped.
module huff_code_rx
  import huff_code_rx_pkg::*;
#(
  parameter int NUM_SYM = HUFF_NUM_SYM,
  parameter int LEN_W   = HUFF_LEN_W,
  parameter int MAX_LEN = HUFF_MAX_LEN,
  parameter int CODE_W  = HUFF_CODE_W
) (
  input  logic              Clk_in,
  input  logic              n_Rst,
  input  logic              Start_in,
  input  logic              In,
  input  logic              In_vld,
  output logic [CODE_W-1:0] Code0,
  output logic [CODE_W-1:0] Code1,
  output logic [CODE_W-1:0] Code2,
  output logic [CODE_W-1:0] Code3,
  output logic [CODE_W-1:0] Code4,
  output logic [CODE_W-1:0] Code5,
  output logic [CODE_W-1:0] Code6,
  output logic [CODE_W-1:0] Code7,
  output logic [CODE_W-1:0] Code8,
  output logic [CODE_W-1:0] Code9,
  output logic [3:0]        Sym_cnt,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [1:0]        state
);

  localparam int CBITS = CODE_W - LEN_W;

  huff_state_e       state_q;
  logic [LEN_W-1:0]  len_q;
  logic [3:0]        sym_q;
  logic              busy_q, done_q, err_q;
  logic [CODE_W-1:0] code_q [NUM_SYM];

  logic              accept, len_shift, len_fin, len_last, len_bad, len_zero;
  logic              code_shift, code_fin, code_last, code_clr, len_load, store;
  logic [LEN_W-1:0]  len_nxt;
  logic [CBITS-1:0]  code_nxt;
  logic [CODE_W-1:0] store_word;

  // Datapath control decoded from the current state and the sampled bit.
  always_comb begin
    accept     = In_vld & ~Start_in;
    len_shift  = accept & (state_q == ST_LEN);
    len_fin    = len_shift & len_last;
    code_shift = accept & (state_q == ST_CODE);
    code_fin   = code_shift & code_last;
    len_bad    = (len_nxt > LEN_W'(MAX_LEN));
    len_zero   = (len_nxt == '0);
    store      = (len_fin & len_zero) | code_fin;
    store_word = code_fin ? {len_q, code_nxt} : '0;
    len_load   = Start_in | store;
    code_clr   = Start_in | store;
  end

  huff_shift_acc #(.ACC_W(LEN_W), .CNT_W(LEN_W)) u_len (
    .clk_i      (Clk_in),
    .rst_ni     (n_Rst),
    .clr_i      (1'b0),
    .load_i     (len_load),
    .load_cnt_i (LEN_W'(LEN_W)),
    .shift_i    (len_shift),
    .bit_i      (In),
    .acc_nxt_o  (len_nxt),
    .last_o     (len_last)
  );

  huff_shift_acc #(.ACC_W(CBITS), .CNT_W(LEN_W)) u_code (
    .clk_i      (Clk_in),
    .rst_ni     (n_Rst),
    .clr_i      (code_clr),
    .load_i     (len_fin),
    .load_cnt_i (len_nxt),
    .shift_i    (code_shift),
    .bit_i      (In),
    .acc_nxt_o  (code_nxt),
    .last_o     (code_last)
  );

  // Frame FSM with registered status outputs and the code table.
  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      sym_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_SYM; i++) code_q[i] <= '0;
    end else if (Start_in) begin
      state_q <= ST_LEN;
      len_q   <= '0;
      sym_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_SYM; i++) code_q[i] <= '0;
    end else begin
      case (state_q)
        ST_LEN: begin
          if (len_fin && len_bad) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (len_fin && !len_zero) begin
            len_q   <= len_nxt;
            state_q <= ST_CODE;
          end
        end
        default: ;
      endcase
      if (store) begin
        for (int i = 0; i < NUM_SYM; i++) begin
          if (sym_q == 4'(i)) code_q[i] <= store_word;
        end
        sym_q <= sym_q + 4'd1;
        len_q <= '0;
        if (sym_q == 4'(NUM_SYM - 1)) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          state_q <= ST_LEN;
        end
      end
    end
  end

  assign Code0   = code_q[0];
  assign Code1   = code_q[1];
  assign Code2   = code_q[2];
  assign Code3   = code_q[3];
  assign Code4   = code_q[4];
  assign Code5   = code_q[5];
  assign Code6   = code_q[6];
  assign Code7   = code_q[7];
  assign Code8   = code_q[8];
  assign Code9   = code_q[9];
  assign Sym_cnt = sym_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Err     = err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_huff_code_rx.sv
// Randomized bench for huff_code_rx. The reference re-parses the whole list of
// bits accepted since the last Start_in after every clock and derives the
// expected table and status from the frame format directly.
module tb_huff_code_rx;

  logic        Clk_in = 1'b0;
  logic        n_Rst, Start_in, In, In_vld;
  logic [12:0] Code0, Code1, Code2, Code3, Code4, Code5, Code6, Code7, Code8, Code9;
  logic [3:0]  Sym_cnt;
  logic        Busy, Done, Err;
  logic [1:0]  state;
  logic [12:0] got_code [10];

  huff_code_rx dut (
    .Clk_in(Clk_in), .n_Rst(n_Rst), .Start_in(Start_in), .In(In), .In_vld(In_vld),
    .Code0(Code0), .Code1(Code1), .Code2(Code2), .Code3(Code3), .Code4(Code4),
    .Code5(Code5), .Code6(Code6), .Code7(Code7), .Code8(Code8), .Code9(Code9),
    .Sym_cnt(Sym_cnt), .Busy(Busy), .Done(Done), .Err(Err), .state(state)
  );

  assign got_code[0] = Code0;
  assign got_code[1] = Code1;
  assign got_code[2] = Code2;
  assign got_code[3] = Code3;
  assign got_code[4] = Code4;
  assign got_code[5] = Code5;
  assign got_code[6] = Code6;
  assign got_code[7] = Code7;
  assign got_code[8] = Code8;
  assign got_code[9] = Code9;

  // Clock.
  always #5 Clk_in = ~Clk_in;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state.
  bit          started;
  bit          rx_q[$];   // bits accepted since the last Start_in
  bit          tx_q[$];   // bits of the frame being sent
  logic [12:0] exp_code [10];
  logic [3:0]  exp_sym;
  logic [1:0]  exp_state;
  logic        exp_busy, exp_done, exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      if (n_errs <= 40) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Parse the accepted bit list symbol by symbol.
  function automatic void model_eval();
    int n, pos, sym, len;
    int unsigned c;
    for (int i = 0; i < 10; i++) exp_code[i] = '0;
    exp_sym = '0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_state = 2'd0;
    if (!started) return;
    n = rx_q.size();
    pos = 0;
    sym = 0;
    exp_state = 2'd1;
    exp_busy  = 1'b1;
    while (sym < 10) begin
      if (pos + 4 > n) break;
      len = 0;
      for (int k = 0; k < 4; k++) len = len * 2 + int'(rx_q[pos + k]);
      pos += 4;
      if (len > 9) begin
        exp_err = 1'b1; exp_busy = 1'b0; exp_state = 2'd0;
        break;
      end
      if (pos + len > n) begin
        exp_state = 2'd2;
        break;
      end
      c = 0;
      for (int k = 0; k < len; k++) c = c * 2 + int'(rx_q[pos + k]);
      pos += len;
      exp_code[sym] = 13'(len * 512 + int'(c));
      sym++;
    end
    if (sym == 10) begin
      exp_done = 1'b1; exp_busy = 1'b0; exp_state = 2'd3;
    end
    exp_sym = 4'(sym);
  endfunction

  task automatic check_all(input string tag);
    model_eval();
    check({tag, ".state"}, 32'(state), 32'(exp_state));
    check({tag, ".sym"}, 32'(Sym_cnt), 32'(exp_sym));
    check({tag, ".busy"}, 32'(Busy), 32'(exp_busy));
    check({tag, ".done"}, 32'(Done), 32'(exp_done));
    check({tag, ".err"}, 32'(Err), 32'(exp_err));
    for (int i = 0; i < 10; i++)
      check($sformatf("%s.code%0d", tag, i), 32'(got_code[i]), 32'(exp_code[i]));
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge,
  // compare just after it.
  task automatic step(input bit s, input bit v, input bit b, input string tag);
    @(negedge Clk_in);
    Start_in = s;
    In_vld   = v;
    In       = b;
    @(posedge Clk_in);
    if (s) begin
      rx_q.delete();
      started = 1'b1;
    end else if (v && started) begin
      rx_q.push_back(b);
    end
    #1 check_all(tag);
  endtask

  task automatic add_sym(input int len, input int unsigned c);
    for (int k = 3; k >= 0; k--) tx_q.push_back(bit'((len >> k) & 1));
    for (int k = len - 1; k >= 0; k--) tx_q.push_back(bit'((c >> k) & 1));
  endtask

  task automatic add_rand_sym();
    int len;
    len = int'($urandom_range(0, 9));
    add_sym(len, $urandom_range(0, (1 << len) - 1));
  endtask

  // Send tx_q[first..last-1] with random idle gaps (junk on In during gaps).
  task automatic send_range(input int first, input int last, input int gap_pct, input string tag);
    for (int i = first; i < last; i++) begin
      for (int g = 0; g < 4 && int'($urandom_range(0, 99)) < gap_pct; g++)
        step(1'b0, 1'b0, bit'($urandom_range(0, 1)), {tag, ".gap"});
      step(1'b0, 1'b1, tx_q[i], tag);
    end
  endtask

  task automatic idle_junk(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, bit'($urandom_range(0, 1)), tag);
  endtask

  task automatic start_frame(input string tag);
    tx_q.delete();
    step(1'b1, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_sym;
    // Reset and idle behaviour.
    n_Rst = 1'b0; Start_in = 1'b0; In = 1'b0; In_vld = 1'b0;
    started = 1'b0;
    repeat (2) @(negedge Clk_in);
    check_all("reset");
    n_Rst = 1'b1;
    idle_junk(4, "idle");

    // Ten L=3 code 101 symbols, back to back.
    start_frame("t1.start");
    for (int i = 0; i < 10; i++) add_sym(3, 3'b101);
    send_range(0, tx_q.size(), 0, "t1");
    check("t1.code0_const", 32'(Code0), 32'h0605);
    check("t1.code9_const", 32'(Code9), 32'h0605);
    check("t1.done_const", 32'(Done), 32'd1);
    idle_junk(3, "t1.after");

    // L=9 code 0x1A5 as symbol 0 with gaps.
    start_frame("t2.start");
    add_sym(9, 9'h1A5);
    for (int i = 1; i < 10; i++) add_rand_sym();
    send_range(0, tx_q.size(), 40, "t2");
    check("t2.code0_const", 32'(Code0), 32'h13A5);

    // Illegal length 4'hC on symbol 2.
    start_frame("t3.start");
    add_rand_sym();
    add_rand_sym();
    add_sym(12, 0);
    send_range(0, tx_q.size(), 20, "t3");
    check("t3.err_const", 32'(Err), 32'd1);
    check("t3.state_const", 32'(state), 32'd0);
    idle_junk(4, "t3.after");

    // Zero-length symbol 4.
    start_frame("t4.start");
    for (int i = 0; i < 4; i++) add_sym(int'($urandom_range(1, 9)), $urandom_range(0, 511) & 1);
    add_sym(0, 0);
    for (int i = 5; i < 10; i++) add_rand_sym();
    send_range(0, tx_q.size(), 30, "t4");
    check("t4.code4_const", 32'(Code4), 32'h0000);

    // Start_in together with In_vld in symbol 5's code bits.
    start_frame("t5.start");
    for (int i = 0; i < 10; i++) add_sym(3, $urandom_range(0, 7));
    send_range(0, 40, 0, "t5");
    step(1'b1, 1'b1, tx_q[40], "t5.abort");
    check("t5.sym_const", 32'(Sym_cnt), 32'd0);
    tx_q.delete();
    for (int i = 0; i < 10; i++) add_rand_sym();
    send_range(0, tx_q.size(), 20, "t5.new");

    // Asynchronous reset in the middle of symbol 1's code bits.
    start_frame("t6.start");
    for (int i = 0; i < 10; i++) add_sym(5, $urandom_range(0, 31));
    send_range(0, 15, 0, "t6");
    #2 n_Rst = 1'b0;
    started = 1'b0;
    rx_q.delete();
    #1 check_all("t6.rst");
    @(negedge Clk_in);
    n_Rst = 1'b1;
    idle_junk(5, "t6.idle");

    // Random frames, some with an illegal length somewhere.
    for (int f = 0; f < 6; f++) begin
      start_frame("rand.start");
      bad_sym = (f % 2 == 1) ? int'($urandom_range(0, 9)) : 99;
      for (int i = 0; i < 10; i++) begin
        if (i == bad_sym) add_sym(int'($urandom_range(10, 15)), 0);
        else add_rand_sym();
      end
      send_range(0, tx_q.size(), int'($urandom_range(0, 50)), "rand");
      idle_junk(2, "rand.after");
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/huff_code_rx.md
HUFF_CODE_RX -- requirements
Module: huff_code_rx

Interface
REQ-001 Parameter NUM_SYM, default 10, is the number of code-table entries received per frame.
REQ-002 Parameter LEN_W, default 4, is the width of the serial length field.
REQ-003 Parameter MAX_LEN, default 9, is the largest legal code length.
REQ-004 Parameter CODE_W, default 13, is the width of each code-table word: [12:9] length, [8:0] code bits right-aligned.
REQ-005 Clk_in  input  1  single clock; all state changes on its rising edge.
REQ-006 n_Rst  input  1  reset, asynchronous assert, active-low.
REQ-007 Start_in  input  1  one-cycle pulse; clears the table and arms reception of a new frame.
REQ-008 In  input  1  serial data bit, MSB-first.
REQ-009 In_vld  input  1  qualifies In; a bit is sampled only on edges where In_vld=1.
REQ-010 Code0..Code9  output  13 each  received code-table words, registered.
REQ-011 Sym_cnt  output  4  index of the symbol currently being received (0..NUM_SYM).
REQ-012 Busy  output  1  high from accepted Start_in until Done or Err.
REQ-013 Done  output  1  high when all NUM_SYM entries are stored; held until Start_in or reset.
REQ-014 Err  output  1  sticky illegal-length flag; cleared only by Start_in or reset.
REQ-015 state  output  2  current FSM state encoding, for debug.

Function
REQ-016 Serial frame per symbol: LEN_W length bits MSB-first, then L code bits MSB-first (bit L-1 down to bit 0); symbols back-to-back in order 0..NUM_SYM-1.
REQ-017 Cycles with In_vld=0 inside a frame are idle gaps of any length and shall not change any register.
REQ-018 FSM states: IDLE=00, LEN=01, CODE=10, DONE=11; ERR is reported via Err with state returning to IDLE.
REQ-019 IDLE: In_vld ignored; Start_in -> LEN, Sym_cnt=0, all CodeN=0, Done=0, Err=0, Busy=1.
REQ-020 LEN: each valid bit shifts into a 4-bit length register; after the 4th bit, L>MAX_LEN -> Err=1, Busy=0, IDLE; L=0 -> store word {0,9'b0}, advance symbol; else -> CODE with bit counter=L.
REQ-021 CODE: each valid bit shifts into a 9-bit accumulator from the LSB; after the L-th bit the word {L, accumulator} is written to Code[Sym_cnt] on that same edge.
REQ-022 Unused upper code bits above L-1 shall be 0 in the stored word.
REQ-023 After a store, Sym_cnt increments; if it reaches NUM_SYM -> DONE, Done=1, Busy=0, else -> LEN with length and accumulator cleared.
REQ-024 Latency: CodeN and Done become visible one clock after the edge that samples the last bit of that symbol.
REQ-025 DONE: In_vld ignored; only Start_in leaves DONE (-> LEN with full clear per REQ-019).
REQ-026 Start_in in LEN or CODE aborts the frame and restarts per REQ-019; partially received symbol is discarded.
REQ-027 Start_in and In_vld on the same edge: Start_in wins, the bit is discarded.
REQ-028 Previously stored entries remain stable on the outputs until Start_in or reset.

Reset
REQ-029 n_Rst low shall asynchronously force: state=IDLE, CodeN=0, Sym_cnt=0, Busy=0, Done=0, Err=0, internal shift/counter registers=0.
REQ-030 Reset asserted mid-frame discards all progress; after release the block waits in IDLE for Start_in.

Structure
REQ-031 NUM_SYM, LEN_W, MAX_LEN, CODE_W, and the FSM state encodings shall live in a shared package used by both the transmitter and this block.
REQ-032 One sub-module, huff_shift_acc (bit counter plus shift accumulator with load/clear), is natural and shall be reused for length and code fields.

Verification
REQ-033 Reset then Start_in, ten symbols each L=3 code 3'b101, no gaps -> Code0..Code9=13'h0605, Done=1 at 70 valid bits + 1 clock, Busy=0.
REQ-034 Symbol 0 L=9 code 9'h1A5 with random In_vld gaps -> Code0=13'h13A5, no change during gap cycles.
REQ-035 Symbol 2 length field 4'hC -> Err=1, Busy=0, state=IDLE, Code0/Code1 retained, Code2=0.
REQ-036 Symbol 4 length 0 -> Code4=13'h0000, Sym_cnt advances directly to 5 without code bits.
REQ-037 Start_in asserted during symbol 5 code bits, same edge as In_vld -> all CodeN=0, Sym_cnt=0, bit discarded, new frame received correctly.
REQ-038 n_Rst pulsed low mid-CODE, asynchronously between clock edges -> all outputs 0 immediately, In_vld ignored until next Start_in.
